// File: rtl/exidle_rx.sv
// -----------------------------------------------------------------------------
// exidle_rx
//
// Receive side of the 35-bit ExBus idle/status channel. This block sits on the
// inbound word stream from the link decoder.
//
// It strips idle and FIFO-error status words out of the stream. All other
// words are forwarded downstream unchanged through a single output register.
//
// From the stripped words it recovers:
//   - the far end's aux bits
//   - the far end's clear-to-send (CTS)
//   - interrupt events
//   - FIFO-error events
//
// A watchdog declares the link down when status words stop arriving.
//
// Parameters
//   LGWATCH      log2 of the watchdog timeout in clocks
//
// Ports
//   i_clk        system clock
//   i_reset_n    synchronous active-low reset
//   i_stb        inbound word valid
//   i_word       inbound word
//   o_busy       stall to upstream (held output word not yet taken)
//   o_stb        outbound word valid
//   o_word       outbound word
//   i_busy       stall from downstream
//   o_aux        far-end aux bits from the most recent special word
//   o_cts        far-end clear-to-send from the most recent idle word
//   o_int        one-cycle pulse: far-end interrupt reported
//   o_fifo_err   one-cycle pulse: far-end FIFO error reported
//   o_err_count  saturating count of FIFO-error words received
//   o_link_up    a status word was seen within the last 2^LGWATCH clocks
// -----------------------------------------------------------------------------
module exidle_rx #(
   parameter int LGWATCH = 25
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_stb,
   input  logic [34:0] i_word,
   output logic        o_busy,
   output logic        o_stb,
   output logic [34:0] o_word,
   input  logic        i_busy,
   output logic [1:0]  o_aux,
   output logic        o_cts,
   output logic        o_int,
   output logic        o_fifo_err,
   output logic [7:0]  o_err_count,
   output logic        o_link_up
);

   localparam logic [LGWATCH:0] WD_ONE    = {{LGWATCH{1'b0}}, 1'b1};
   localparam logic [7:0]       ERR_MAX   = 8'hFF;
   localparam logic [7:0]       ERR_ONE   = 8'h01;

   // Word classification helpers
   function automatic logic is_special(input logic [34:0] w);
      return (w[34:33] == 2'b11);
   endfunction

   function automatic logic is_idle(input logic [34:0] w);
      return is_special(w) && w[30];
   endfunction

   function automatic logic is_fifo_err(input logic [34:0] w);
      return is_special(w) && (w[30:28] == 3'b011);
   endfunction

   // Registered state
   logic               stb_q,     stb_d;
   logic [34:0]        word_q,    word_d;
   logic [1:0]         aux_q,     aux_d;
   logic               cts_q,     cts_d;
   logic               int_q,     int_d;
   logic               ferr_q,    ferr_d;
   logic [7:0]         err_cnt_q, err_cnt_d;
   logic               link_q,    link_d;
   logic [LGWATCH-1:0] wd_cnt_q,  wd_cnt_d;
   logic               wd_flag_q, wd_flag_d;

   // Combinational decode
   logic               special_s;
   logic               idle_s;
   logic               ferr_word_s;
   logic               status_s;
   logic               busy_s;
   logic               accept_s;
   logic [LGWATCH-1:0] wd_inc_s;
   logic               wd_carry_s;

   // Decode the inbound word and the single accept rule shared by all word types
   always_comb begin
      special_s   = is_special(i_word);
      idle_s      = is_idle(i_word);
      ferr_word_s = is_fifo_err(i_word);
      status_s    = idle_s || ferr_word_s;
      // A held word blocks every word type, so status never overtakes data
      busy_s      = stb_q && i_busy;
      accept_s    = i_stb && !busy_s;
      {wd_carry_s, wd_inc_s} = {1'b0, wd_cnt_q} + WD_ONE;
   end

   // Next-state logic for the forwarding register, status outputs and watchdog
   always_comb begin
      stb_d     = stb_q;
      word_d    = word_q;
      aux_d     = aux_q;
      cts_d     = cts_q;
      int_d     = 1'b0;
      ferr_d    = 1'b0;
      err_cnt_d = err_cnt_q;
      link_d    = link_q;
      wd_cnt_d  = wd_cnt_q;
      wd_flag_d = wd_flag_q;

      // Forwarding register: load on a forwarded word, release when downstream
      // is not stalling. A consumed status word still lets the release happen.
      if (accept_s && !status_s) begin
         stb_d  = 1'b1;
         word_d = i_word;
      end else if (!i_busy) begin
         stb_d  = 1'b0;
      end else begin
         stb_d  = stb_q;
      end

      // Any accepted special word refreshes the aux bits
      if (accept_s && special_s) begin
         aux_d = i_word[32:31];
      end else begin
         aux_d = aux_q;
      end

      // Idle word carries CTS and the interrupt flag
      if (accept_s && idle_s) begin
         cts_d = i_word[29];
         int_d = i_word[28];
      end else begin
         cts_d = cts_q;
         int_d = 1'b0;
      end

      // FIFO-error word pulses and bumps the saturating counter
      if (accept_s && ferr_word_s) begin
         ferr_d = 1'b1;
         if (err_cnt_q == ERR_MAX) begin
            err_cnt_d = err_cnt_q;
         end else begin
            err_cnt_d = err_cnt_q + ERR_ONE;
         end
      end else begin
         ferr_d    = 1'b0;
         err_cnt_d = err_cnt_q;
      end

      // Watchdog: a status accept takes priority over a carry on the same
      // cycle. Once the flag is set the counter stops.
      if (accept_s && status_s) begin
         wd_cnt_d  = {LGWATCH{1'b0}};
         wd_flag_d = 1'b0;
         link_d    = 1'b1;
      end else if (!wd_flag_q) begin
         wd_cnt_d = wd_inc_s;
         if (wd_carry_s) begin
            wd_flag_d = 1'b1;
            link_d    = 1'b0;
         end else begin
            wd_flag_d = 1'b0;
            link_d    = link_q;
         end
      end else begin
         wd_cnt_d  = wd_cnt_q;
         wd_flag_d = wd_flag_q;
         link_d    = link_q;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         stb_q     <= 1'b0;
         word_q    <= 35'h0;
         aux_q     <= 2'b00;
         cts_q     <= 1'b0;
         int_q     <= 1'b0;
         ferr_q    <= 1'b0;
         err_cnt_q <= 8'h00;
         link_q    <= 1'b0;
         wd_cnt_q  <= {LGWATCH{1'b0}};
         wd_flag_q <= 1'b0;
      end else begin
         stb_q     <= stb_d;
         word_q    <= word_d;
         aux_q     <= aux_d;
         cts_q     <= cts_d;
         int_q     <= int_d;
         ferr_q    <= ferr_d;
         err_cnt_q <= err_cnt_d;
         link_q    <= link_d;
         wd_cnt_q  <= wd_cnt_d;
         wd_flag_q <= wd_flag_d;
      end
   end

   assign o_busy      = busy_s;
   assign o_stb       = stb_q;
   assign o_word      = word_q;
   assign o_aux       = aux_q;
   assign o_cts       = cts_q;
   assign o_int       = int_q;
   assign o_fifo_err  = ferr_q;
   assign o_err_count = err_cnt_q;
   assign o_link_up   = link_q;

endmodule
